alu_cmd_issuer: RTL

Initiator-side sequencer for the 32-bit combinational ALU. It accepts operation commands over a valid/ready interface and drives the ALU's A/B/control inputs. It captures the ALU result and zero flag, returns them on a valid/ready response channel, and optionally writes them back to an internal accumulator so commands can be chained. MUL is held for extra cycles so the multiplier path gets a multicycle budget.

---
 rtl/alu_cmd_issuer_if.sv | 38 +++
 rtl/alu_cmd_issuer.sv | 92 +++++++++
 2 files changed

// File: rtl/alu_cmd_issuer_if.sv
// Command, response and ALU-drive signals of the ALU command issuer.
// The slave modport is the issuer; the master modport is its environment.
`timescale 1ns/1ps
interface alu_cmd_issuer_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic             cmd_a_sel;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_wb;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_illegal;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a_sel, cmd_a, cmd_b, cmd_wb,
    input  alu_result, alu_zero, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_control,
    output rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a_sel, cmd_a, cmd_b, cmd_wb,
    output alu_result, alu_zero, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_control,
    input  rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Sequencer that issues one command at a time to a combinational ALU,
// captures its result into a response register and an optional accumulator.
`timescale 1ns/1ps
module alu_cmd_issuer #(
  parameter int                 WIDTH     = 32,
  parameter int                 MUL_WAIT  = 2,
  parameter logic [WIDTH-1:0]   ACC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  alu_cmd_issuer_if.slave  bus,
  output logic [WIDTH-1:0] acc,
  output logic             busy
);

  localparam logic [3:0] OP_MUL = 4'd10;
  localparam int         CW     = (MUL_WAIT > 0) ? $clog2(MUL_WAIT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          wb_q;
  logic          illegal_q;

  // Gated by rst so no command appears accepted while reset is held.
  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign busy          = (state != IDLE);

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the values from before the edge, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      wb_q            <= 1'b0;
      illegal_q       <= 1'b0;
      bus.alu_a       <= '0;
      bus.alu_b       <= '0;
      bus.alu_control <= 4'd0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_result  <= '0;
      bus.rsp_zero    <= 1'b0;
      bus.rsp_illegal <= 1'b0;
      acc             <= ACC_RESET;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.alu_a       <= bus.cmd_a_sel ? acc : bus.cmd_a;
            bus.alu_b       <= bus.cmd_b;
            bus.alu_control <= bus.cmd_op;
            wb_q            <= bus.cmd_wb;
            illegal_q       <= (bus.cmd_op > 4'd10);
            if (bus.cmd_op == OP_MUL && MUL_WAIT > 0) begin
              state <= WAIT;
              cnt   <= CW'(MUL_WAIT);
            end else begin
              state <= EXEC;
            end
          end
        end
        // Operands stay put here, giving the multiplier path extra cycles.
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= EXEC;
        end
        EXEC: begin
          bus.rsp_result  <= bus.alu_result;
          bus.rsp_zero    <= bus.alu_zero;
          bus.rsp_illegal <= illegal_q;
          bus.rsp_valid   <= 1'b1;
          if (wb_q && !illegal_q) acc <= bus.alu_result;
          state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
